mem_arbiter: RTL

- Shares the single-port 32x8 instruction/data memory between two requesters: port 0 is the multicycle stack CPU and port 1 is a loader/debug port.
- Uses req/gnt ownership with bounded bursts and round-robin tie-breaking.
- Sits between the requesters and the memory's memread/memwrite/address/data pins.
- Registers read data back to the owning port.

---
 rtl/mem_arbiter_pkg.sv | 8 +
 rtl/mem_arbiter_if.sv | 15 +
 rtl/mem_arbiter_rr_pick2.sv | 13 +
 rtl/mem_arbiter.sv | 71 +++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding, port ids and default widths for the memory arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester port (req/gnt ownership plus beat fields and read return).
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the port that did not own last wins.
module rr_pick2 import mem_arb_pkg::*; (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick_valid,
    output logic pick_id
);
    always_comb begin
        pick_valid = req0 || req1;
        pick_id    = (req0 && req1) ? ~last : (req1 ? P1 : P0);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port memory between two req/gnt ports with round-robin ties and bounded bursts.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      p0,
    mem_arbiter_if.slave      p1,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);
    state_t     state;
    state_t     own_nx;
    logic       last, beat0, beat1, rel0, rel1, cnt_wrap, pick_valid, pick_id;
    logic [3:0] beat_cnt;
    assign beat0    = (state == OWN0) && p0.req;
    assign beat1    = (state == OWN1) && p1.req;
    assign cnt_wrap = beat_cnt == CNT_LAST;
    assign rel0     = (state == OWN0) && (!p0.req || (cnt_wrap && p1.req));
    assign rel1     = (state == OWN1) && (!p1.req || (cnt_wrap && p0.req));
    assign own_nx   = pick_id ? OWN1 : OWN0;
    assign p0.gnt   = state == OWN0;
    assign p1.gnt   = state == OWN1;
    assign memread   = (beat0 && !p0.we) || (beat1 && !p1.we);
    assign memwrite  = (beat0 && p0.we) || (beat1 && p1.we);
    assign mem_addr  = beat0 ? p0.addr : (beat1 ? p1.addr : '0);
    assign mem_wdata = beat0 ? p0.wdata : (beat1 ? p1.wdata : '0);
    // The owner is masked out, so at handover the picker can only name the other port.
    rr_pick2 u_pick (
        .req0       (p0.req && (state != OWN0)),
        .req1       (p1.req && (state != OWN1)),
        .last       (last),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= P1;
            beat_cnt  <= '0;
            p0.rvalid <= 1'b0;
            p1.rvalid <= 1'b0;
            p0.rdata  <= '0;
            p1.rdata  <= '0;
        end else begin
            beat_cnt  <= ((beat0 || beat1) && !cnt_wrap) ? beat_cnt + 4'd1 : '0;
            p0.rvalid <= beat0 && !p0.we;
            p1.rvalid <= beat1 && !p1.we;
            if (beat0 && !p0.we) p0.rdata <= mem_rdata;
            if (beat1 && !p1.we) p1.rdata <= mem_rdata;
            case (state)
                IDLE: state <= pick_valid ? own_nx : IDLE;
                OWN0: if (rel0) begin
                    state <= pick_valid ? own_nx : IDLE;
                    last  <= P0;
                end
                OWN1: if (rel1) begin
                    state <= pick_valid ? own_nx : IDLE;
                    last  <= P1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
